irq_controller: RTL and testbench



---
 rtl/irq_ctrl_pkg.sv | 38 +++
 rtl/irq_priority_sel.sv | 45 ++++
 rtl/irq_controller.sv | 183 ++++++++++++++++++
 tb/tb_irq_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
// Module   : irq_ctrl_pkg
// Brief    : Shared types, register map and helpers for the interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_ctrl_pkg;

   localparam int IRQ_ID_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_e;

   localparam int REG_ENABLE  = 0;
   localparam int REG_PENDING = 1;
   localparam int REG_ACTIVE  = 2;
   localparam int REG_EOI     = 3;
   localparam int REG_RAW     = 4;
   localparam int REG_SWSET   = 5;

   // (id + 1) mod num_src, used as the round-robin search origin.
   function automatic logic [IRQ_ID_W-1:0] next_index(input logic [IRQ_ID_W-1:0] id,
                                                      input int num_src);
      logic [IRQ_ID_W:0] inc;
      inc = {1'b0, id} + (IRQ_ID_W+1)'(1);
      if (inc >= (IRQ_ID_W+1)'(num_src)) begin
         return '0;
      end
      return inc[IRQ_ID_W-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/irq_priority_sel.sv
// ============================================================================
// Module   : irq_priority_sel
// Brief    : Combinational search for the first set bit of a vector, starting
//            at a given index and wrapping around.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_priority_sel
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0]  eligible,
   input  logic [IRQ_ID_W-1:0] start_idx,
   output logic                found,
   output logic [IRQ_ID_W-1:0] sel_idx
);

   localparam logic [IRQ_ID_W:0] c_num_src = (IRQ_ID_W+1)'(NUM_SRC);

   logic [IRQ_ID_W:0] w_pos;
   logic [NUM_SRC-1:0] w_shifted;

   always_comb begin
      found     = 1'b0;
      sel_idx   = '0;
      w_pos     = '0;
      w_shifted = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_pos = {1'b0, start_idx} + (IRQ_ID_W+1)'(i);
         if (w_pos >= c_num_src) begin
            w_pos = w_pos - c_num_src;
         end
         w_shifted = eligible >> w_pos;
         if (!found && w_shifted[0]) begin
            found   = 1'b1;
            sel_idx = w_pos[IRQ_ID_W-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// ============================================================================
// Module   : irq_controller
// Brief    : Memory-mapped interrupt controller: edge capture into pending bits,
//            masking, single-request arbitration and req/ack/EOI handshake.
//            Optional macro IRQC_ROUND_ROBIN_EN selects round-robin search.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_controller
   import irq_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SRC    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  write_enable,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic [NUM_SRC-1:0]    irq_src,
   output logic                  cpu_irq,
   input  logic                  cpu_irq_ack,
   output logic [IRQ_ID_W-1:0]   irq_id
);

   irq_state_e          state_q, state_d;
   logic [NUM_SRC-1:0]  pending_q, pending_d;
   logic [NUM_SRC-1:0]  enable_q, enable_d;
   logic [NUM_SRC-1:0]  src_prev_q, src_prev_d;
   logic [IRQ_ID_W-1:0] irq_id_q, irq_id_d;

   logic                w_wr_enable, w_wr_pending, w_wr_eoi, w_wr_swset;
   logic [NUM_SRC-1:0]  w_wdata_src;
   logic                w_ack, w_eoi;
   logic [NUM_SRC-1:0]  w_ack_mask, w_set, w_clr, w_eligible;
   logic                w_found;
   logic [IRQ_ID_W-1:0] w_sel_idx, w_start;
   logic                w_unused_data;

   // ------------------------------------------------------------------------
   // Bus write decode
   // ------------------------------------------------------------------------
   assign w_wr_enable   = write_enable && (addr == ADDR_WIDTH'(REG_ENABLE));
   assign w_wr_pending  = write_enable && (addr == ADDR_WIDTH'(REG_PENDING));
   assign w_wr_eoi      = write_enable && (addr == ADDR_WIDTH'(REG_EOI));
   assign w_wr_swset    = write_enable && (addr == ADDR_WIDTH'(REG_SWSET));
   assign w_wdata_src   = data_in[NUM_SRC-1:0];
   assign w_unused_data = &{1'b0, data_in[DATA_WIDTH-1:NUM_SRC]};

   assign w_ack = (state_q == ST_REQ) && cpu_irq_ack;
   assign w_eoi = (state_q == ST_SERVICE) && w_wr_eoi;

   always_comb begin
      w_ack_mask = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_ack_mask[i] = w_ack && (irq_id_q == IRQ_ID_W'(i));
      end
   end

   // ------------------------------------------------------------------------
   // Pending / enable / edge-capture next state (set dominates clear)
   // ------------------------------------------------------------------------
   always_comb begin
      src_prev_d = irq_src;
      w_set      = (irq_src & ~src_prev_q) | (w_wr_swset ? w_wdata_src : '0);
      w_clr      = (w_wr_pending ? w_wdata_src : '0) | w_ack_mask;
      pending_d  = (pending_q & ~w_clr) | w_set;
      enable_d   = w_wr_enable ? w_wdata_src : enable_q;
   end

   assign w_eligible = pending_q & enable_q;

   // ------------------------------------------------------------------------
   // Search origin
   // ------------------------------------------------------------------------
`ifdef IRQC_ROUND_ROBIN_EN
   logic [IRQ_ID_W-1:0] last_id_q, last_id_d;

   always_comb begin
      last_id_d = w_ack ? irq_id_q : last_id_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_id_q <= '0;
      end else begin
         last_id_q <= last_id_d;
      end
   end

   assign w_start = next_index(last_id_q, NUM_SRC);
`else
   assign w_start = '0;
`endif

   irq_priority_sel #(
      .NUM_SRC   (NUM_SRC)
   ) u_sel (
      .eligible  (w_eligible),
      .start_idx (w_start),
      .found     (w_found),
      .sel_idx   (w_sel_idx)
   );

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         enable_q   <= '0;
         src_prev_q <= '0;
         irq_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         enable_q   <= enable_d;
         src_prev_q <= src_prev_d;
         irq_id_q   <= irq_id_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      irq_id_d = irq_id_q;
      case (state_q)
         ST_IDLE: begin
            if (w_found) begin
               state_d  = ST_REQ;
               irq_id_d = w_sel_idx;
            end
         end
         ST_REQ: begin
            if (w_ack) begin
               state_d = ST_SERVICE;
            end
         end
         ST_SERVICE: begin
            if (w_eoi) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      cpu_irq = (state_q == ST_REQ);
      irq_id  = irq_id_q;
   end

   // ------------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------------
   always_comb begin
      data_out = '0;
      if (addr == ADDR_WIDTH'(REG_ENABLE)) begin
         data_out[NUM_SRC-1:0] = enable_q;
      end else if (addr == ADDR_WIDTH'(REG_PENDING)) begin
         data_out[NUM_SRC-1:0] = pending_q;
      end else if (addr == ADDR_WIDTH'(REG_ACTIVE)) begin
         data_out[9:8]          = state_q;
         data_out[IRQ_ID_W-1:0] = irq_id_q;
      end else if (addr == ADDR_WIDTH'(REG_RAW)) begin
         data_out[NUM_SRC-1:0] = irq_src;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
// ============================================================================
// Module   : tb_irq_controller
// Brief    : Directed self-checking bench for irq_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_controller;

   localparam int AW = 4;
   localparam int DW = 32;
   localparam int NS = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] data_in = '0;
   logic          write_enable = 1'b0;
   logic [DW-1:0] data_out;
   logic [NS-1:0] irq_src = '0;
   logic          cpu_irq;
   logic          cpu_irq_ack = 1'b0;
   logic [3:0]    irq_id;

   int n_cmp  = 0;
   int n_fail = 0;

`ifdef IRQC_ROUND_ROBIN_EN
   localparam logic [3:0] FIRST_ID  = 4'd1;
   localparam logic [3:0] SECOND_ID = 4'd0;
`else
   localparam logic [3:0] FIRST_ID  = 4'd0;
   localparam logic [3:0] SECOND_ID = 4'd1;
`endif

   irq_controller #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .NUM_SRC      (NS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .addr         (addr),
      .data_in      (data_in),
      .write_enable (write_enable),
      .data_out     (data_out),
      .irq_src      (irq_src),
      .cpu_irq      (cpu_irq),
      .cpu_irq_ack  (cpu_irq_ack),
      .irq_id       (irq_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      addr = a;
      data_in = d;
      write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
      data_in = '0;
   endtask

   task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] v);
      addr = a;
      #1;
      v = data_out;
   endtask

   task automatic pulse(input logic [NS-1:0] s);
      irq_src = s;
      tick();
      irq_src = '0;
   endtask

   task automatic ack();
      cpu_irq_ack = 1'b1;
      tick();
      cpu_irq_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      irq_src = '0;
      cpu_irq_ack = 1'b0;
      write_enable = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [DW-1:0] v;
      tick();
      tick();
      rst = 1'b0;
      n_cmp++; if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_irq: got %b want 0", cpu_irq); end
      n_cmp++; if (irq_id !== 4'd0) begin n_fail++; $display("FAIL rst_irq_id: got %0d want 0", irq_id); end
      rd(0, v); n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_enable: got %h want 0", v); end
      rd(1, v); n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_pending: got %h want 0", v); end
      rd(2, v); n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_active: got %h want 0", v); end
   endtask

   task automatic test_single_src();
      logic [DW-1:0] v;
      do_reset();
      wr(0, 32'h3);
      pulse(4'b0010);
      rd(1, v); n_cmp++; if (v !== 32'h2) begin n_fail++; $display("FAIL t1_pending: got %h want 2", v); end
      n_cmp++; if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL t1_irq_n1: got %b want 0", cpu_irq); end
      rd(4, v); n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL t1_raw: got %h want 0", v); end
      tick();
      n_cmp++; if (cpu_irq !== 1'b1) begin n_fail++; $display("FAIL t1_irq_n2: got %b want 1", cpu_irq); end
      n_cmp++; if (irq_id !== 4'd1) begin n_fail++; $display("FAIL t1_id: got %0d want 1", irq_id); end
      ack();
      n_cmp++; if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL t1_irq_after_ack: got %b want 0", cpu_irq); end
      rd(1, v); n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL t1_pending_after_ack: got %h want 0", v); end
      rd(2, v); n_cmp++; if (v !== 32'h201) begin n_fail++; $display("FAIL t1_active_service: got %h want 201", v); end
      ack();
      rd(2, v); n_cmp++; if (v !== 32'h201) begin n_fail++; $display("FAIL t1_stray_ack: got %h want 201", v); end
      wr(3, 32'h0);
      rd(2, v); n_cmp++; if (v !== 32'h001) begin n_fail++; $display("FAIL t1_active_eoi: got %h want 001", v); end
   endtask

   task automatic test_priority();
      logic [DW-1:0] v;
      do_reset();
      wr(0, 32'h3);
      pulse(4'b0011);
      tick();
      n_cmp++; if (cpu_irq !== 1'b1 || irq_id !== FIRST_ID) begin n_fail++; $display("FAIL t2_first: got irq=%b id=%0d want irq=1 id=%0d", cpu_irq, irq_id, FIRST_ID); end
      ack();
      rd(1, v); n_cmp++; if (v !== (32'h1 << SECOND_ID)) begin n_fail++; $display("FAIL t2_pending_mid: got %h want %h", v, 32'h1 << SECOND_ID); end
      wr(3, 32'h0);
      n_cmp++; if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL t2_idle_gap: got %b want 0", cpu_irq); end
      tick();
      n_cmp++; if (cpu_irq !== 1'b1 || irq_id !== SECOND_ID) begin n_fail++; $display("FAIL t2_second: got irq=%b id=%0d want irq=1 id=%0d", cpu_irq, irq_id, SECOND_ID); end
      ack();
      wr(3, 32'h0);
      tick();
      tick();
      n_cmp++; if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL t2_quiet: got %b want 0", cpu_irq); end
   endtask

   task automatic test_masked();
      logic [DW-1:0] v;
      do_reset();
      pulse(4'b0100);
      tick();
      rd(1, v); n_cmp++; if (v !== 32'h4) begin n_fail++; $display("FAIL t3_pending_masked: got %h want 4", v); end
      n_cmp++; if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL t3_masked_irq: got %b want 0", cpu_irq); end
      wr(0, 32'h4);
      n_cmp++; if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL t3_irq_w1: got %b want 0", cpu_irq); end
      tick();
      n_cmp++; if (cpu_irq !== 1'b1 || irq_id !== 4'd2) begin n_fail++; $display("FAIL t3_irq_w2: got irq=%b id=%0d want irq=1 id=2", cpu_irq, irq_id); end
      wr(0, 32'h0);
      wr(1, 32'h4);
      wr(3, 32'h0);
      rd(2, v); n_cmp++; if (cpu_irq !== 1'b1 || v !== 32'h102) begin n_fail++; $display("FAIL t3_req_held: got irq=%b active=%h want irq=1 active=102", cpu_irq, v); end
      ack();
      rd(2, v); n_cmp++; if (cpu_irq !== 1'b0 || v !== 32'h202) begin n_fail++; $display("FAIL t3_ack: got irq=%b active=%h want irq=0 active=202", cpu_irq, v); end
   endtask

   task automatic test_set_clear();
      logic [DW-1:0] v;
      do_reset();
      wr(5, 32'h8);
      rd(1, v); n_cmp++; if (v !== 32'h8) begin n_fail++; $display("FAIL t4_swset: got %h want 8", v); end
      wr(1, 32'h8);
      rd(1, v); n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL t4_w1c: got %h want 0", v); end
      irq_src = 4'b1000;
      wr(1, 32'h8);
      irq_src = '0;
      rd(1, v); n_cmp++; if (v !== 32'h8) begin n_fail++; $display("FAIL t4_set_wins: got %h want 8", v); end
      pulse(4'b1000);
      tick();
      pulse(4'b1000);
      wr(0, 32'h8);
      tick();
      n_cmp++; if (cpu_irq !== 1'b1 || irq_id !== 4'd3) begin n_fail++; $display("FAIL t4_req3: got irq=%b id=%0d want irq=1 id=3", cpu_irq, irq_id); end
      ack();
      wr(3, 32'h0);
      tick();
      tick();
      rd(1, v); n_cmp++; if (cpu_irq !== 1'b0 || v !== 32'h0) begin n_fail++; $display("FAIL t4_collapse: got irq=%b pending=%h want irq=0 pending=0", cpu_irq, v); end
   endtask

   task automatic test_reset_mid_service();
      logic [DW-1:0] v;
      do_reset();
      wr(0, 32'h3);
      pulse(4'b0011);
      tick();
      ack();
      rd(2, v); n_cmp++; if (v[9:8] !== 2'd2) begin n_fail++; $display("FAIL t5_in_service: got state=%0d want 2", v[9:8]); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (cpu_irq !== 1'b0 || irq_id !== 4'd0) begin n_fail++; $display("FAIL t5_outputs: got irq=%b id=%0d want irq=0 id=0", cpu_irq, irq_id); end
      rd(1, v); n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL t5_pending: got %h want 0", v); end
      rd(0, v); n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL t5_enable: got %h want 0", v); end
      tick();
      tick();
      rd(2, v); n_cmp++; if (cpu_irq !== 1'b0 || v !== 32'h0) begin n_fail++; $display("FAIL t5_lost: got irq=%b active=%h want irq=0 active=0", cpu_irq, v); end
   endtask

`ifdef IRQC_ROUND_ROBIN_EN
   task automatic test_round_robin();
      logic [3:0] exp_ids [5] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
      do_reset();
      wr(0, 32'hF);
      wr(5, 32'hF);
      tick();
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if (cpu_irq !== 1'b1 || irq_id !== exp_ids[k]) begin n_fail++; $display("FAIL t6_rr_%0d: got irq=%b id=%0d want irq=1 id=%0d", k, cpu_irq, irq_id, exp_ids[k]); end
         ack();
         wr(5, 32'hF);
         wr(3, 32'h0);
         tick();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_src();
      test_priority();
      test_masked();
      test_set_clear();
      test_reset_mid_service();
`ifdef IRQC_ROUND_ROBIN_EN
      test_round_robin();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
